// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace unit: FSM states and trace-entry layout.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default geometry of a trace entry (DATA_W=32, RF_AW=5, CNT_W=16)
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RF_AW  = 5;
    localparam int unsigned DEF_CNT_W  = 16;

    // Entry layout, MSB to LSB: {cycle, pc, rf_we, rf_addr, rf_wdata, dm_we, dm_addr, dm_wdata}
    function automatic int unsigned entry_w(int unsigned cnt_w, int unsigned data_w,
                                            int unsigned rf_aw);
        return cnt_w + data_w + 2 + rf_aw + 3 * data_w;
    endfunction

    function automatic int unsigned off_dm_addr(int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned off_dm_we(int unsigned data_w);
        return 2 * data_w;
    endfunction

    function automatic int unsigned off_rf_wdata(int unsigned data_w);
        return 2 * data_w + 1;
    endfunction

    function automatic int unsigned off_rf_addr(int unsigned data_w);
        return 3 * data_w + 1;
    endfunction

    function automatic int unsigned off_rf_we(int unsigned data_w, int unsigned rf_aw);
        return 3 * data_w + 1 + rf_aw;
    endfunction

    function automatic int unsigned off_pc(int unsigned data_w, int unsigned rf_aw);
        return 3 * data_w + 2 + rf_aw;
    endfunction

    function automatic int unsigned off_cycle(int unsigned data_w, int unsigned rf_aw);
        return 4 * data_w + 2 + rf_aw;
    endfunction

    localparam int unsigned DEF_ENTRY_W = DEF_CNT_W + DEF_DATA_W + 2 + DEF_RF_AW + 3 * DEF_DATA_W;

endpackage

// File: rtl/cpu_trace_unit_fifo.sv
// First-word-fall-through trace FIFO with a registered head output.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_dout;
    logic [AW:0]      w_wptr_nxt;
    logic [AW:0]      w_rptr_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_dout;

    // Next pointers and next head value; a write landing on the new head slot bypasses the array
    always_comb begin
        w_wptr_nxt = r_wptr + (AW + 1)'(w_do_push);
        w_rptr_nxt = r_rptr + (AW + 1)'(w_do_pop);
        w_dout_nxt = '0;
        if (w_wptr_nxt != w_rptr_nxt) begin
            if (w_do_push && (w_rptr_nxt[AW-1:0] == r_wptr[AW-1:0])) begin
                w_dout_nxt = din;
            end else begin
                w_dout_nxt = r_mem[w_rptr_nxt[AW-1:0]];
            end
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    // Pointers and registered head output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_dout <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_dout <= w_dout_nxt;
        end
    end

endmodule

// File: rtl/cpu_trace_unit.sv
// CPU execution tracer: run/halt FSM, cycle counter, event capture and drop accounting.
module cpu_trace_unit
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RF_AW       = 5,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned CYCLE_LIMIT = 60
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [DATA_W-1:0]                         pc_i,
    input  logic                                      rf_we_i,
    input  logic [RF_AW-1:0]                          rf_addr_i,
    input  logic [DATA_W-1:0]                         rf_wdata_i,
    input  logic                                      dm_we_i,
    input  logic [DATA_W-1:0]                         dm_addr_i,
    input  logic [DATA_W-1:0]                         dm_wdata_i,
    output logic                                      tr_valid_o,
    input  logic                                      tr_ready_i,
    output logic [CNT_W+DATA_W+2+RF_AW+3*DATA_W-1:0]  tr_data_o,
    output logic                                      halt_o,
    output logic                                      done_o,
    output logic                                      overflow_o,
    output logic [CNT_W-1:0]                          drop_cnt_o,
    output logic [CNT_W-1:0]                          cycle_o
);

    localparam int unsigned ENTRY_W = entry_w(CNT_W, DATA_W, RF_AW);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cycle;
    logic [CNT_W-1:0]     r_drop_cnt;
    logic                 r_overflow;
    logic                 r_halt;
    logic                 r_done;
    logic                 w_limit_hit;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [ENTRY_W-1:0]   w_entry;

    assign w_limit_hit = (CYCLE_LIMIT != 0) && (r_cycle == CNT_W'(CYCLE_LIMIT - 1));
    assign w_pop       = !w_empty && tr_ready_i;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;

    assign tr_valid_o  = !w_empty;
    assign halt_o      = r_halt;
    assign done_o      = r_done;
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;
    assign cycle_o     = r_cycle;

    // Next-state logic; capture is suppressed on the edge that leaves RUN
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_limit_hit) w_state_nxt = ST_HALT;
                else             w_push_req  = rf_we_i || dm_we_i;
            end
            ST_HALT: if (w_empty) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered halt/done flags derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_halt  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_halt  <= (w_state_nxt == ST_HALT) || (w_state_nxt == ST_DONE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Cycle counter: cleared on start, counts every RUN edge, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_cycle <= '0;
        end else if (r_state == ST_RUN) begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Pack the trace entry from the pre-increment cycle and sampled inputs
    always_comb begin
        w_entry = '0;
        w_entry[0 +: DATA_W]                           = dm_wdata_i;
        w_entry[off_dm_addr(DATA_W) +: DATA_W]         = dm_addr_i;
        w_entry[off_dm_we(DATA_W)]                     = dm_we_i;
        w_entry[off_rf_wdata(DATA_W) +: DATA_W]        = rf_wdata_i;
        w_entry[off_rf_addr(DATA_W) +: RF_AW]          = rf_addr_i;
        w_entry[off_rf_we(DATA_W, RF_AW)]              = rf_we_i;
        w_entry[off_pc(DATA_W, RF_AW) +: DATA_W]       = pc_i;
        w_entry[off_cycle(DATA_W, RF_AW) +: CNT_W]     = r_cycle;
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_entry),
        .dout  (tr_data_o),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_cpu_trace_unit.sv
// Directed self-checking bench for cpu_trace_unit.
module tb_cpu_trace_unit;

    localparam int EW_A = 16 + 32 + 2 + 5 + 96;
    localparam int EW_B = 4 + 32 + 2 + 5 + 96;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            start_b;
    logic [31:0]     pc;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [31:0]     rf_wdata;
    logic            dm_we;
    logic [31:0]     dm_addr;
    logic [31:0]     dm_wdata;
    logic            tr_ready;

    logic            tr_valid;
    logic [EW_A-1:0] tr_data;
    logic            halt, done, overflow;
    logic [15:0]     drop_cnt, cycle;

    logic            tr_valid_b;
    logic [EW_B-1:0] tr_data_b;
    logic            halt_b, done_b, overflow_b;
    logic [3:0]      drop_cnt_b, cycle_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cpu_trace_unit #(
        .DATA_W(32), .RF_AW(5), .DEPTH(4), .CNT_W(16), .CYCLE_LIMIT(60)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_i(pc),
        .rf_we_i(rf_we), .rf_addr_i(rf_addr), .rf_wdata_i(rf_wdata),
        .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .tr_valid_o(tr_valid), .tr_ready_i(tr_ready), .tr_data_o(tr_data),
        .halt_o(halt), .done_o(done), .overflow_o(overflow),
        .drop_cnt_o(drop_cnt), .cycle_o(cycle)
    );

    cpu_trace_unit #(
        .DATA_W(32), .RF_AW(5), .DEPTH(4), .CNT_W(4), .CYCLE_LIMIT(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pc_i(pc),
        .rf_we_i(rf_we), .rf_addr_i(rf_addr), .rf_wdata_i(rf_wdata),
        .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .tr_valid_o(tr_valid_b), .tr_ready_i(1'b1), .tr_data_o(tr_data_b),
        .halt_o(halt_b), .done_o(done_b), .overflow_o(overflow_b),
        .drop_cnt_o(drop_cnt_b), .cycle_o(cycle_b)
    );

    function automatic logic [EW_A-1:0] mk(input logic [15:0] cyc, input logic [31:0] p,
                                           input logic rwe, input logic [4:0] ra,
                                           input logic [31:0] rd, input logic dwe,
                                           input logic [31:0] da, input logic [31:0] dd);
        return {cyc, p, rwe, ra, rd, dwe, da, dd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; start_b = 0; pc = '0;
        rf_we = 0; rf_addr = '0; rf_wdata = '0;
        dm_we = 0; dm_addr = '0; dm_wdata = '0;
        tr_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        step();
    endtask

    task automatic start_run();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #2;
        total_cnt++;
        if (tr_valid !== 1'b0 || halt !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL reset_flags: valid=%b halt=%b done=%b ovf=%b, expected all 0",
                     tr_valid, halt, done, overflow);
        end else pass_cnt++;
        total_cnt++;
        if (cycle !== 16'd0 || drop_cnt !== 16'd0 || tr_data !== '0) begin
            $display("FAIL reset_counters: cycle=%0d drop=%0d data=%h, expected 0", cycle, drop_cnt, tr_data);
        end else pass_cnt++;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_basic_halt();
        int n;
        logic [EW_A-1:0] exp_e;
        do_reset();
        start_run();
        step(); step(); step();
        total_cnt++;
        if (cycle !== 16'd3) $display("FAIL basic_cycle3: got %0d, expected 3", cycle);
        else pass_cnt++;
        pc = 32'h100; rf_we = 1; rf_addr = 5'd8; rf_wdata = 32'd5;
        step();
        rf_we = 0; rf_addr = '0; rf_wdata = '0;
        exp_e = mk(16'd3, 32'h100, 1'b1, 5'd8, 32'd5, 1'b0, 32'd0, 32'd0);
        total_cnt++;
        if (tr_valid !== 1'b1 || tr_data !== exp_e)
            $display("FAIL basic_entry: valid=%b data=%h, expected valid=1 data=%h", tr_valid, tr_data, exp_e);
        else pass_cnt++;
        n = 4;
        while (halt !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        total_cnt++;
        if (n !== 60 || halt !== 1'b1)
            $display("FAIL basic_halt_edges: halt after %0d RUN edges (halt=%b), expected 60", n, halt);
        else pass_cnt++;
        total_cnt++;
        if (cycle !== 16'd60 || done !== 1'b0 || tr_valid !== 1'b1 || tr_data !== exp_e)
            $display("FAIL basic_halt_state: cycle=%0d done=%b valid=%b, expected 60/0/1", cycle, done, tr_valid);
        else pass_cnt++;
        tr_ready = 1;
        n = 0;
        while (done !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        tr_ready = 0;
        total_cnt++;
        if (done !== 1'b1 || halt !== 1'b1 || tr_valid !== 1'b0)
            $display("FAIL basic_done: done=%b halt=%b valid=%b, expected 1/1/0", done, halt, tr_valid);
        else pass_cnt++;
        rf_we = 1; start = 1;
        step(); step();
        rf_we = 0; start = 0;
        total_cnt++;
        if (tr_valid !== 1'b0 || done !== 1'b1 || cycle !== 16'd60)
            $display("FAIL done_ignores: valid=%b done=%b cycle=%0d, expected 0/1/60", tr_valid, done, cycle);
        else pass_cnt++;
    endtask

    task automatic test_dual_event();
        logic [EW_A-1:0] exp_e;
        do_reset();
        start_run();
        pc = 32'h200; rf_we = 1; rf_addr = 5'd16; rf_wdata = 32'd7;
        dm_we = 1; dm_addr = 32'h4; dm_wdata = 32'd9;
        step();
        idle_inputs();
        step();
        exp_e = mk(16'd0, 32'h200, 1'b1, 5'd16, 32'd7, 1'b1, 32'h4, 32'd9);
        total_cnt++;
        if (tr_valid !== 1'b1 || tr_data !== exp_e)
            $display("FAIL dual_entry: valid=%b data=%h, expected %h", tr_valid, tr_data, exp_e);
        else pass_cnt++;
        tr_ready = 1;
        step();
        tr_ready = 0;
        total_cnt++;
        if (tr_valid !== 1'b0) $display("FAIL dual_single: valid=%b after one pop, expected 0", tr_valid);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [EW_A-1:0] ev [7];
        logic [EW_A-1:0] order [4];
        do_reset();
        start_run();
        for (int i = 0; i < 6; i++) begin
            pc = 32'h300 + 32'(4 * i); rf_we = 1; rf_addr = 5'(i + 1); rf_wdata = 32'h10 + 32'(i);
            ev[i] = mk(16'(i), pc, 1'b1, rf_addr, rf_wdata, 1'b0, 32'd0, 32'd0);
            step();
        end
        rf_we = 0;
        total_cnt++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd2)
            $display("FAIL ovf_flags: overflow=%b drop=%0d, expected 1/2", overflow, drop_cnt);
        else pass_cnt++;
        total_cnt++;
        if (tr_valid !== 1'b1 || tr_data !== ev[0])
            $display("FAIL ovf_head: data=%h, expected %h", tr_data, ev[0]);
        else pass_cnt++;
        pc = 32'h400; rf_we = 1; rf_addr = 5'd20; rf_wdata = 32'hAA; tr_ready = 1;
        ev[6] = mk(16'd6, 32'h400, 1'b1, 5'd20, 32'hAA, 1'b0, 32'd0, 32'd0);
        step();
        rf_we = 0;
        total_cnt++;
        if (drop_cnt !== 16'd2) $display("FAIL full_pushpop_drop: drop=%0d, expected 2", drop_cnt);
        else pass_cnt++;
        order[0] = ev[1]; order[1] = ev[2]; order[2] = ev[3]; order[3] = ev[6];
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (tr_valid !== 1'b1 || tr_data !== order[k])
                $display("FAIL pop_order_%0d: valid=%b data=%h, expected %h", k, tr_valid, tr_data, order[k]);
            else pass_cnt++;
            step();
        end
        tr_ready = 0;
        total_cnt++;
        if (tr_valid !== 1'b0) $display("FAIL ovf_drained: valid=%b, expected 0 after 4 pops", tr_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        logic [EW_A-1:0] exp_e;
        do_reset();
        start_run();
        for (int i = 0; i < 3; i++) begin
            rf_we = 1; rf_addr = 5'(i); rf_wdata = 32'(i);
            step();
        end
        rf_we = 0;
        step();
        total_cnt++;
        if (tr_valid !== 1'b1 || cycle !== 16'd4)
            $display("FAIL midrun_pre: valid=%b cycle=%0d, expected 1/4", tr_valid, cycle);
        else pass_cnt++;
        rst = 1;
        #2;
        total_cnt++;
        if (tr_valid !== 1'b0 || cycle !== 16'd0 || tr_data !== '0)
            $display("FAIL midrun_async: valid=%b cycle=%0d data=%h, expected 0/0/0", tr_valid, cycle, tr_data);
        else pass_cnt++;
        step();
        rst = 0;
        rf_we = 1;
        step();
        rf_we = 0;
        total_cnt++;
        if (tr_valid !== 1'b0 || cycle !== 16'd0)
            $display("FAIL midrun_idle: valid=%b cycle=%0d, expected 0/0", tr_valid, cycle);
        else pass_cnt++;
        start_run();
        pc = 32'h500; rf_we = 1; rf_addr = 5'd3; rf_wdata = 32'h33;
        step();
        rf_we = 0;
        exp_e = mk(16'd0, 32'h500, 1'b1, 5'd3, 32'h33, 1'b0, 32'd0, 32'd0);
        total_cnt++;
        if (tr_data !== exp_e || cycle !== 16'd1)
            $display("FAIL midrun_restart: data=%h cycle=%0d, expected %h / 1", tr_data, cycle, exp_e);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_c;
        do_reset();
        start_b = 1;
        step();
        start_b = 0;
        exp_c = 4'd0;
        total_cnt++;
        if (cycle_b !== exp_c) $display("FAIL wrap_start: cycle=%0d, expected 0", cycle_b);
        else pass_cnt++;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_c = exp_c + 4'd1;
            total_cnt++;
            if (cycle_b !== exp_c || halt_b !== 1'b0)
                $display("FAIL wrap_step_%0d: cycle=%0d halt=%b, expected %0d/0", i, cycle_b, halt_b, exp_c);
            else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic_halt();
        test_dual_event();
        test_overflow();
        test_reset_midrun();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
